// File: rtl/payload_counter.sv
`default_nettype none
// ============================================================================
// Module      : payload_counter
// Description : Captures a serial length field after a flag is detected,
//               streams that many payload bits, then releases the detector.
// Revision    : 1.0 - initial release
// ============================================================================
module payload_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det,
  input  logic             sin,
  output logic             en,
  output logic             busy,
  output logic             pvalid,
  output logic             pout,
  output logic [LEN_W-1:0] len,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  localparam int                 c_IDX_W    = (LEN_W > 1) ? $clog2(LEN_W) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(LEN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_PAY  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   w_len_next;

  // Length field arrives MSB first, so each new bit enters at the LSB.
  generate
    if (LEN_W > 1) begin : g_shift_wide
      assign w_len_next = {len[LEN_W-2:0], sin};
    end else begin : g_shift_narrow
      assign w_len_next = sin;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
      en          <= 1'b0;
      busy        <= 1'b0;
      pvalid      <= 1'b0;
      pout        <= 1'b0;
      len         <= '0;
      frame_cnt   <= 8'd0;
      err         <= 1'b0;
    end else begin
      en     <= 1'b0;
      err    <= 1'b0;
      pvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (det) begin
            r_state <= S_LEN;
            busy    <= 1'b1;
            len     <= '0;
            r_idx   <= '0;
          end
        end
        S_LEN: begin
          if (!det) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            len   <= w_len_next;
            r_idx <= r_idx + c_IDX_W'(1);
            if (r_idx == c_IDX_LAST) begin
              if (w_len_next != '0) begin
                r_state     <= S_PAY;
                r_remaining <= w_len_next;
              end else begin
                r_state <= S_REL;
                en      <= 1'b1;
              end
            end
          end
        end
        S_PAY: begin
          if (!det) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            pvalid      <= 1'b1;
            pout        <= sin;
            r_remaining <= r_remaining - LEN_W'(1);
            // The last payload bit and the release pulse share a cycle so
            // the det-to-en latency stays 1 + LEN_W + len.
            if (r_remaining == LEN_W'(1)) begin
              r_state <= S_REL;
              en      <= 1'b1;
            end
          end
        end
        S_REL: begin
          r_state   <= S_IDLE;
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_payload_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_payload_counter
// Description : Self-checking bench for payload_counter against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_payload_counter;

  localparam int LEN_W = 4;
  localparam int MAXC  = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             det_drv;
  logic             sin;
  logic             use_det;
  logic             det;
  logic             en;
  logic             busy;
  logic             pvalid;
  logic             pout;
  logic             err;
  logic [LEN_W-1:0] len;
  logic [7:0]       frame_cnt;

  logic [6:0]       d_sr;
  logic             w;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected timeline: entry c is the stimulus before edge c and the outputs after it.
  bit               t_det  [MAXC];
  bit               t_sin  [MAXC];
  bit               x_en   [MAXC];
  bit               x_err  [MAXC];
  bit               x_pv   [MAXC];
  bit               x_busy [MAXC];
  bit               x_pout [MAXC];
  logic [LEN_W-1:0] x_len  [MAXC];
  logic [7:0]       x_fc   [MAXC];
  int               ncyc;

  int               m_fc;
  logic [LEN_W-1:0] m_len;
  bit               m_pout;

  int          en_cnt, err_cnt, pv_cnt, en_at, pv_at, busy_err;
  logic [15:0] pbits;

  payload_counter #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .det       (det),
    .sin       (sin),
    .en        (en),
    .busy      (busy),
    .pvalid    (pvalid),
    .pout      (pout),
    .len       (len),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign det = use_det ? w : det_drv;

  // Upstream flag detector: raises w on serial 0111110, drops it once released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sr <= 7'd0;
      w    <= 1'b0;
    end else begin
      d_sr <= {d_sr[5:0], sin};
      if (en)
        w <= 1'b0;
      else if ({d_sr[5:0], sin} == 7'b0111110)
        w <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input bit d, input bit s, input bit e, input bit er, input bit pv, input bit b);
    if (ncyc >= MAXC) begin
      $display("FAIL timeline: got %0d entries expected < %0d", ncyc, MAXC);
      $fatal(1, "timeline overflow");
    end
    t_det[ncyc]  = d;
    t_sin[ncyc]  = s;
    x_en[ncyc]   = e;
    x_err[ncyc]  = er;
    x_pv[ncyc]   = pv;
    x_busy[ncyc] = b;
    x_pout[ncyc] = m_pout;
    x_len[ncyc]  = m_len;
    x_fc[ncyc]   = 8'(m_fc);
    ncyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) push(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One frame: det seen, LEN_W length bits, L payload bits, one release cycle.
  // abort_at is the frame-relative edge where det is low (-1 for none).
  task automatic frame(input int L, input logic [15:0] pay, input int abort_at, input bit det_rel);
    logic [LEN_W-1:0] lv;
    bit               s;
    lv    = LEN_W'(L);
    m_len = '0;
    push(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= LEN_W + L; i++) begin
      if (i == abort_at) begin
        push(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        return;
      end
      if (i <= LEN_W) begin
        s     = lv[LEN_W-i];
        m_len = lv >> (LEN_W - i);
        push(1'b1, s, (i == LEN_W + L), 1'b0, 1'b0, 1'b1);
      end else begin
        s      = pay[i-LEN_W-1];
        m_pout = s;
        push(1'b1, s, (i == LEN_W + L), 1'b0, 1'b1, 1'b1);
      end
    end
    m_fc = (m_fc + 1) % 256;
    push(det_rel, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_seg();
    en_cnt = 0; err_cnt = 0; pv_cnt = 0; en_at = -1; pv_at = -1; busy_err = -1; pbits = '0;
    for (int c = 0; c < ncyc; c++) begin
      det_drv = t_det[c];
      sin     = t_sin[c];
      @(posedge clk);
      #1;
      check($sformatf("c%0d_en", c),     32'(en),        32'(x_en[c]));
      check($sformatf("c%0d_err", c),    32'(err),       32'(x_err[c]));
      check($sformatf("c%0d_pvalid", c), 32'(pvalid),    32'(x_pv[c]));
      check($sformatf("c%0d_busy", c),   32'(busy),      32'(x_busy[c]));
      check($sformatf("c%0d_pout", c),   32'(pout),      32'(x_pout[c]));
      check($sformatf("c%0d_len", c),    32'(len),       32'(x_len[c]));
      check($sformatf("c%0d_fcnt", c),   32'(frame_cnt), 32'(x_fc[c]));
      if (en) begin
        en_cnt++;
        if (en_at < 0) en_at = c + 1;
      end
      if (err) begin
        err_cnt++;
        busy_err = int'(busy);
      end
      if (pvalid) begin
        pv_cnt++;
        if (pv_at < 0) pv_at = c + 1;
        pbits = {pbits[14:0], pout};
      end
    end
    ncyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time %0t expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] seq35;
    int          en_c, wf_c, pv35;

    rst = 1'b1; det_drv = 1'b0; sin = 1'b0; use_det = 1'b0;
    m_fc = 0; m_len = '0; m_pout = 1'b0; ncyc = 0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_outputs", 32'({en, busy, pvalid, pout, err, len, frame_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // len=3, payload 1,0,1 on the first edge after reset release
    frame(3, 16'b101, -1, 1'b0);
    idle(2);
    run_seg();
    check("len3_len",    32'(len),       32'd3);
    check("len3_pv_cnt", 32'(pv_cnt),    32'd3);
    check("len3_pout",   32'(pbits),     32'b101);
    check("len3_pv_at",  32'(pv_at),     32'd6);
    check("len3_en_cnt", 32'(en_cnt),    32'd1);
    check("len3_en_at",  32'(en_at),     32'd8);
    check("len3_fcnt",   32'(frame_cnt), 32'd1);

    // zero-length frame
    frame(0, 16'd0, -1, 1'b0);
    idle(2);
    run_seg();
    check("len0_pv_cnt", 32'(pv_cnt),    32'd0);
    check("len0_en_at",  32'(en_at),     32'd5);
    check("len0_fcnt",   32'(frame_cnt), 32'd2);

    // len=15 with det dropped after the sixth payload bit
    frame(15, 16'($urandom), LEN_W + 7, 1'b0);
    idle(2);
    run_seg();
    check("abort_err_cnt", 32'(err_cnt),   32'd1);
    check("abort_en_cnt",  32'(en_cnt),    32'd0);
    check("abort_pv_cnt",  32'(pv_cnt),    32'd6);
    check("abort_busy",    32'(busy_err),  32'd0);
    check("abort_fcnt",    32'(frame_cnt), 32'd2);

    // asynchronous reset in the middle of the payload
    det_drv = 1'b1;
    for (int k = 0; k < LEN_W + 3; k++) begin
      sin = 1'b1;
      @(posedge clk);
      #1;
    end
    check("midpay_busy",   32'(busy),   32'd1);
    check("midpay_pvalid", 32'(pvalid), 32'd1);
    #2;
    rst     = 1'b1;
    det_drv = 1'b0;
    #1;
    check("async_rst_outputs", 32'({en, busy, pvalid, pout, err, len, frame_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_fc = 0; m_len = '0; m_pout = 1'b0;
    idle(4);
    run_seg();
    check("post_rst_en_cnt",  32'(en_cnt),  32'd0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

    // 256 back-to-back len=1 frames, det re-asserted right after release
    for (int f = 0; f < 256; f++) frame(1, 16'($urandom), -1, 1'b1);
    idle(2);
    run_seg();
    check("wrap_en_cnt", 32'(en_cnt),    32'd256);
    check("wrap_fcnt",   32'(frame_cnt), 32'd0);

    // randomized frames, aborts, release-cycle det values and gaps
    for (int f = 0; f < 80; f++) begin
      int L, ab;
      L  = int'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LEN_W + L)) : -1;
      frame(L, 16'($urandom), ab, 1'($urandom));
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    run_seg();

    // chained with the flag detector
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    use_det = 1'b1;
    seq35   = 17'b000_0111110_0_0010_11;
    en_c = -1; wf_c = -1; pv35 = 0;
    for (int c = 0; c < 40; c++) begin
      sin = (c < 17) ? seq35[16-c] : 1'b0;
      @(posedge clk);
      #1;
      if (en && en_c < 0) en_c = c;
      if (en_c >= 0 && !w && wf_c < 0) wf_c = c;
      if (pvalid) pv35++;
    end
    check("det_en_seen", 32'(en_c >= 0),  32'd1);
    check("det_w_fall",  32'(wf_c - en_c), 32'd1);
    check("det_len",     32'(len),         32'd2);
    check("det_pv_cnt",  32'(pv35),        32'd2);
    check("det_idle",    32'(busy),        32'd0);
    check("det_fcnt",    32'(frame_cnt),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
